// File: rtl/update_lru.sv
// Registered 8-way tree pseudo-LRU update; the result is written back to the PLRU array by the cache controller.
// Optional combinational victim-way hint is built only when UPDATE_LRU_VICTIM_EN is defined.
module update_lru (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       upd_en,
  input  logic [2:0] way_updatelru,
  input  logic [6:0] plru,
  output logic [6:0] p,
  output logic       p_valid
`ifdef UPDATE_LRU_VICTIM_EN
  ,
  output logic [2:0] victim_way
`endif
);

  // Every node on the accessed way's path is turned to point at the opposite half.
  function automatic logic [6:0] plru_next(input logic [2:0] way, input logic [6:0] tree);
    logic [6:0] nxt;
    nxt    = tree;
    nxt[0] = ~way[2];
    case (way[2])
      1'b0:    nxt[1] = ~way[1];
      default: nxt[2] = ~way[1];
    endcase
    case (way[2:1])
      2'b00:   nxt[3] = ~way[0];
      2'b01:   nxt[4] = ~way[0];
      2'b10:   nxt[5] = ~way[0];
      default: nxt[6] = ~way[0];
    endcase
    return nxt;
  endfunction

`ifdef UPDATE_LRU_VICTIM_EN
  function automatic logic [2:0] plru_victim(input logic [6:0] tree);
    logic mid_bit;
    logic leaf_bit;
    case (tree[0])
      1'b0:    mid_bit = tree[1];
      default: mid_bit = tree[2];
    endcase
    case ({tree[0], mid_bit})
      2'b00:   leaf_bit = tree[3];
      2'b01:   leaf_bit = tree[4];
      2'b10:   leaf_bit = tree[5];
      default: leaf_bit = tree[6];
    endcase
    return {tree[0], mid_bit, leaf_bit};
  endfunction
`endif

  logic [6:0] p_next_s;
  logic [6:0] p_r;
  logic       p_valid_r;

  // Next tree value from this cycle's inputs only; no forwarding from p.
  always_comb begin
    p_next_s = 7'b0000000;
    if (upd_en) begin
      p_next_s = plru_next(way_updatelru, plru);
    end else begin
      p_next_s = p_r;
    end
  end

  // Result and strobe registers; reset discards any pending result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_r       <= 7'b0000000;
      p_valid_r <= 1'b0;
    end else begin
      p_r       <= p_next_s;
      p_valid_r <= upd_en;
    end
  end

  assign p       = p_r;
  assign p_valid = p_valid_r;

`ifdef UPDATE_LRU_VICTIM_EN
  logic [2:0] victim_s;

  // Victim walk follows plru directly, independent of upd_en and reset.
  always_comb begin
    victim_s = 3'd0;
    victim_s = plru_victim(plru);
  end

  assign victim_way = victim_s;
`endif

endmodule

// File: tb/tb_update_lru.sv
// Directed and sweep bench for update_lru; victim checks compile in with UPDATE_LRU_VICTIM_EN.
module tb_update_lru;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       upd_en;
  logic [2:0] way;
  logic [6:0] plru;
  logic [6:0] p;
  logic       p_valid;
`ifdef UPDATE_LRU_VICTIM_EN
  logic [2:0] victim_way;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  update_lru dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .upd_en       (upd_en),
    .way_updatelru(way),
    .plru         (plru),
    .p            (p),
    .p_valid      (p_valid)
`ifdef UPDATE_LRU_VICTIM_EN
    ,
    .victim_way   (victim_way)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] model_upd(input logic [2:0] w, input logic [6:0] t);
    logic [6:0] r;
    logic [2:0] i1;
    logic [2:0] i2;
    r     = t;
    r[0]  = ~w[2];
    i1    = 3'd1 + {2'b00, w[2]};
    r[i1] = ~w[1];
    i2    = 3'd3 + {1'b0, w[2], 1'b0} + {2'b00, w[1]};
    r[i2] = ~w[0];
    return r;
  endfunction

  function automatic logic [2:0] model_victim(input logic [6:0] t);
    logic b0;
    logic m;
    logic l;
    b0 = t[0];
    m  = t[3'd1 + {2'b00, b0}];
    l  = t[3'd3 + {1'b0, b0, 1'b0} + {2'b00, m}];
    return {b0, m, l};
  endfunction

  task automatic apply(input logic en, input logic [2:0] w, input logic [6:0] t);
    upd_en = en;
    way    = w;
    plru   = t;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [6:0] hold_val;
    rst_n  = 1'b0;
    upd_en = 1'b0;
    way    = 3'd0;
    plru   = 7'd0;
    #12;
    check_eq("reset_p", 32'(p), 32'h00);
    check_eq("reset_valid", 32'(p_valid), 32'h0);
    rst_n = 1'b1;

    apply(1'b1, 3'd0, 7'b0000000);
    check_eq("way0_zero", 32'(p), 32'(7'b0001011));
    check_eq("way0_valid", 32'(p_valid), 32'h1);
    apply(1'b1, 3'd7, 7'b1111111);
    check_eq("way7_ones", 32'(p), 32'(7'b0111010));
    apply(1'b1, 3'd5, 7'b0000000);
    check_eq("way5_zero", 32'(p), 32'(7'b0000100));
    apply(1'b1, 3'd2, 7'b1111111);
    check_eq("way2_offpath", 32'(p), 32'(7'b1111101));

    // asynchronous reset in the middle of a cycle
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_p", 32'(p), 32'h00);
    check_eq("midrst_valid", 32'(p_valid), 32'h0);
    apply(1'b1, 3'd3, 7'b1010101);
    check_eq("rst_held_p", 32'(p), 32'h00);
    check_eq("rst_held_valid", 32'(p_valid), 32'h0);
    rst_n = 1'b1;
    apply(1'b1, 3'd0, 7'b0000000);
    check_eq("post_rst_p", 32'(p), 32'(7'b0001011));
    check_eq("post_rst_valid", 32'(p_valid), 32'h1);

    // hold while inputs toggle
    apply(1'b1, 3'd6, 7'h2A);
    hold_val = model_upd(3'd6, 7'h2A);
    check_eq("hold_load", 32'(p), 32'(hold_val));
    for (int i = 0; i < 5; i++) begin
      apply(1'b0, 3'(i), 7'(8'h55 ^ 8'(i * 37)));
      check_eq("hold_p", 32'(p), 32'(hold_val));
      check_eq("hold_valid", 32'(p_valid), 32'h0);
    end

    // exhaustive sweep, back-to-back
    for (int w = 0; w < 8; w++) begin
      for (int t = 0; t < 128; t++) begin
        apply(1'b1, 3'(w), 7'(t));
        check_eq("sweep_p", 32'(p), 32'(model_upd(3'(w), 7'(t))));
        check_eq("sweep_valid", 32'(p_valid), 32'h1);
`ifdef UPDATE_LRU_VICTIM_EN
        check_eq("sweep_not_victim", 32'(model_victim(p) != 3'(w)), 32'h1);
        check_eq("sweep_victim", 32'(victim_way), 32'(model_victim(7'(t))));
`endif
      end
    end

    apply(1'b0, 3'd0, 7'd0);
    check_eq("valid_drop", 32'(p_valid), 32'h0);

`ifdef UPDATE_LRU_VICTIM_EN
    plru = 7'b0000000;
    #1;
    check_eq("victim_zero", 32'(victim_way), 32'd0);
    plru = 7'b1111111;
    #1;
    check_eq("victim_ones", 32'(victim_way), 32'd7);
    plru = 7'b0000100;
    #1;
    check_eq("victim_0000100", 32'(victim_way), 32'd0);
    plru = 7'b0000001;
    #1;
    check_eq("victim_0000001", 32'(victim_way), 32'd4);
    rst_n = 1'b0;
    plru  = 7'b1111111;
    #1;
    check_eq("victim_in_reset", 32'(victim_way), 32'd7);
    rst_n = 1'b1;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
